aes_round_sequencer: RTL
========================

# aes_round_sequencer

Controller that sequences one AES_encipher core: accepts plaintext blocks over a valid/ready handshake and holds the expanded round keys in a local key store. It pulses the core's start, serves the round key the core asks for through its round index, then captures the ciphertext and returns it over a second valid/ready handshake. It sits between the key-expansion/host side and the encipher datapath and replaces all bench-style round-key feeding.

## Interface
- TIMEOUT, 31: maximum cycles in RUN before the watchdog aborts a block (5-bit counter, 1..31).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  plaintext request valid
- s_ready  out  1  sequencer can accept a block
- s_block  in  128  plaintext
- s_keylen  in  1  0 = AES128, 1 = AES256 (only with AES256_EN)
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_block  out  128  ciphertext
- m_err  out  1  result aborted by watchdog, m_block = 0
- key_we  in  1  key store write strobe
- key_addr  in  4  round-key index
- key_data  in  128  round-key value
- key_drop  out  1  one-cycle pulse: write ignored (busy or addr out of range)
- core_next  out  1  start pulse to core
- core_keylen  out  1  key length to core
- core_block  out  128  block to core
- core_round  in  4  core's current round index
- core_round_key  out  128  key for core_round
- core_new_block  in  128  core output
- core_ready  in  1  core finished

## Operation
- States: IDLE, START, ARM, RUN, DONE.
- IDLE: s_ready=1. On s_valid: latch s_block into core_block, latch keylen, go START.
- START: core_next=1 for exactly this cycle; go ARM.
- ARM: one dead cycle (core_ready ignored, it may still reflect the previous block); go RUN, clear watchdog.
- RUN: on core_ready=1, latch core_new_block into m_block, m_err=0, go DONE. Else increment watchdog; when it reaches TIMEOUT, m_block=0, m_err=1, go DONE.
- DONE: m_valid=1; m_block/m_err stable until m_ready=1, then go IDLE. s_ready=0 in every state but IDLE.
- core_round_key = key_store[core_round], combinational, in all states. core_round beyond last valid index (10 AES128, 14 AES256) returns 0.
- Key writes: accepted only in IDLE with key_addr ≤ last index; otherwise dropped and key_drop pulses next cycle. A write and an s_valid accepted in the same IDLE cycle: the write lands first and is used by that block.
- Key store is not reset (contents undefined after rst); all control state is.

## Timing
- Reset: state IDLE, s_ready=1, m_valid=0, m_err=0, m_block=0, core_next=0, core_block=0, core_keylen=0, key_drop=0, watchdog=0.
- Reset mid-operation: immediate return to IDLE, in-flight block discarded, no m_valid.
- Accept at edge N -> core_next high during cycle N+1 -> RUN from N+3.
- Core ready seen in RUN cycle R -> m_valid from R+1. Minimum total latency accept-to-m_valid = core latency + 3.
- s_ready and key acceptance depend only on state (registered), no combinational path from m_ready.
- Back-to-back throughput: one block per (latency + 4) cycles when m_ready is held high.

## Configuration
- AES256_EN defined: key store 15 entries, s_keylen used, latched into core_keylen, last index 14, addr 11..14 writable when keylen-independent.
- AES256_EN undefined: key store 11 entries, s_keylen port absent, core_keylen tied 0, addr 11..15 always dropped.

## Test plan
- FIPS-197 C.1: write keys 0..10 for key 000102…0f, send 00112233445566778899aabbccddeeff -> m_block 69c4e0d86a7b0430d8cdb78070b4c55a, m_err=0.
- Key write while RUN, addr 3 -> key_drop pulses once, result still matches golden; write addr 12 (AES128) -> key_drop.
- Hold m_ready=0 for 10 cycles in DONE -> m_valid, m_block stable, s_ready=0; release -> next block accepted following cycle.
- Core model never raises core_ready, TIMEOUT=31 -> m_valid with m_err=1, m_block=0 after 31 RUN cycles.
- Assert rst for one cycle during RUN -> all outputs at reset values, no m_valid, next block completes correctly.
- AES256_EN with FIPS-197 C.3 keys 0..14 -> m_block 8ea2b7ca516745bfeafc49904b496089.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//
// Sequences one AES_encipher core. Plaintext blocks are accepted over an s_valid/s_ready
// handshake, then the core is given a one-cycle start pulse. While the core runs, its
// round-key requests are answered from a local key store. The ciphertext is captured when
// the core signals ready, and the result is returned over an m_valid/m_ready handshake. If
// the core never finishes, a watchdog aborts the block and returns m_err=1 with m_block=0.
//
// Optional feature: define AES256_EN to build a 15-entry key store and an s_keylen input.
// Without it, the store has 11 entries, s_keylen is absent and core_keylen is tied to 0.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   s_valid/s_ready     plaintext handshake; s_block data; s_keylen (AES256_EN only)
//   m_valid/m_ready     result handshake; m_block ciphertext; m_err watchdog abort
//   key_we/addr/data    key store write port; key_drop pulses when a write is ignored
//   core_next           start pulse to the core
//   core_keylen         key length to the core
//   core_block          block to the core
//   core_round          round index requested by the core
//   core_round_key      round key served back for core_round
//   core_new_block      core output block
//   core_ready          core finished

module aes_round_sequencer #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_block,
`ifdef AES256_EN
    input  logic         s_keylen,
`endif
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_block,
    output logic         m_err,
    input  logic         key_we,
    input  logic [3:0]   key_addr,
    input  logic [127:0] key_data,
    output logic         key_drop,
    output logic         core_next,
    output logic         core_keylen,
    output logic [127:0] core_block,
    input  logic [3:0]   core_round,
    output logic [127:0] core_round_key,
    input  logic [127:0] core_new_block,
    input  logic         core_ready
);

`ifdef AES256_EN
    localparam int unsigned NumKeys = 15;
    localparam logic [3:0]  LastIdx = 4'd14;
`else
    localparam int unsigned NumKeys = 11;
    localparam logic [3:0]  LastIdx = 4'd10;
`endif
    localparam logic [4:0] TimeoutCnt = TIMEOUT[4:0];

    typedef enum logic [2:0] {StIdle, StStart, StArm, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [4:0]     wdog_q, wdog_d;
    logic [127:0]   m_block_q, m_block_d;
    logic           m_err_q, m_err_d;
    logic [127:0]   core_block_q, core_block_d;
    logic           keylen_q, keylen_d;
    logic           key_drop_q, key_drop_d;
    logic           key_wr_ok;
    logic [3:0]     round_last;

    // Key store holds data only; it is deliberately left out of reset.
    logic [127:0]   key_store [NumKeys];

    // Writes are taken only while idle so a running block never sees its keys change.
    assign key_wr_ok  = key_we && (state_q == StIdle) && (key_addr <= LastIdx);
    assign key_drop_d = key_we && !key_wr_ok;

    always_ff @(posedge clk) begin
        if (key_wr_ok) begin
            key_store[key_addr] <= key_data;
        end
    end

    // Round indices past the last key for the current key length read as zero.
    assign round_last     = keylen_q ? 4'd14 : 4'd10;
    assign core_round_key = (core_round <= round_last) ? key_store[core_round] : 128'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wdog_q       <= 5'd0;
            m_block_q    <= 128'd0;
            m_err_q      <= 1'b0;
            core_block_q <= 128'd0;
            keylen_q     <= 1'b0;
            key_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            m_block_q    <= m_block_d;
            m_err_q      <= m_err_d;
            core_block_q <= core_block_d;
            keylen_q     <= keylen_d;
            key_drop_q   <= key_drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        m_block_d    = m_block_q;
        m_err_d      = m_err_q;
        core_block_d = core_block_q;
        keylen_d     = keylen_q;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        core_next    = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    core_block_d = s_block;
`ifdef AES256_EN
                    keylen_d     = s_keylen;
`endif
                    state_d      = StStart;
                end
            end
            StStart: begin
                core_next = 1'b1;
                state_d   = StArm;
            end
            // core_ready may still show the previous block here, so it is not looked at.
            StArm: begin
                wdog_d  = 5'd0;
                state_d = StRun;
            end
            StRun: begin
                if (core_ready) begin
                    m_block_d = core_new_block;
                    m_err_d   = 1'b0;
                    state_d   = StDone;
                end else begin
                    wdog_d = wdog_q + 5'd1;
                    if (wdog_q + 5'd1 == TimeoutCnt) begin
                        m_block_d = 128'd0;
                        m_err_d   = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign m_block     = m_block_q;
    assign m_err       = m_err_q;
    assign core_block  = core_block_q;
    assign key_drop    = key_drop_q;
`ifdef AES256_EN
    assign core_keylen = keylen_q;
`else
    assign core_keylen = 1'b0;
`endif

endmodule
